nibble_entry: RTL

NIBBLE_ENTRY -- requirements
Module: nibble_entry

---
 rtl/nibble_entry_pkg.sv | 16 +
 rtl/nibble_entry_key_debounce.sv | 63 ++++++
 rtl/nibble_entry.sv | 80 ++++++++
 3 files changed

// File: rtl/nibble_entry_pkg.sv
// Shared types and constants for the hex nibble entry block.
package nibble_entry_pkg;

   // ENTRY collects nibbles; HOLD presents a finished word until the consumer takes it.
   typedef enum logic {
      ENTRY = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Number of hex digits that make up one assembled word.
   localparam int NIBBLES = 4;

   // 10 ms of settling time at a 50 MHz clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/nibble_entry_key_debounce.sv
// Synchronizes a bouncy active-low pushbutton, debounces it and flags each press.
module key_debounce
   import nibble_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic key_n,
   output logic level,
   output logic press
);

   // A one-cycle window still needs a one-bit counter to keep the arithmetic legal.
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] count;
   logic          level_prev;

   // Two-flop synchronizer; resets to the released level so no false press appears.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after it differs for DEBOUNCE_CYCLES straight edges; the count stops at LAST_COUNT so it never wraps.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         level <= 1'b1;
         count <= '0;
      end else if (sync_b == level) begin
         count <= '0;
      end else if (count == LAST_COUNT) begin
         level <= sync_b;
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   // Delayed copy of the debounced level for falling-edge detection.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         level_prev <= 1'b1;
      end else begin
         level_prev <= level;
      end
   end

   // A press is the debounced 1->0 transition, visible for the single cycle after it.
   always_comb begin
      press = level_prev & ~level;
   end

endmodule

// File: rtl/nibble_entry.sv
// Builds a 16-bit word from four pushbutton-entered hex digits and hands it to a consumer.
module nibble_entry
   import nibble_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        key_n,
   input  logic [3:0]  sw_nibble,
   input  logic        clear,
   input  logic        ready,
   output logic [15:0] value,
   output logic [1:0]  digit_idx,
   output logic        valid,
   output logic        press
);

   localparam logic [1:0] LAST_IDX = 2'(NIBBLES - 1);

   state_t state;
   state_t next_state;
   logic   key_level;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .Clock (Clock),
      .Resetn(Resetn),
      .key_n (key_n),
      .level (key_level),
      .press (press)
   );

   // State register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= ENTRY;
      end else begin
         state <= next_state;
      end
   end

   // Move to HOLD on the fourth digit, back to ENTRY when taken; clear overrides everything.
   always_comb begin
      next_state = state;
      case (state)
         ENTRY: if (press && (digit_idx == LAST_IDX)) next_state = HOLD;
         HOLD:  if (ready) next_state = ENTRY;
         default: next_state = ENTRY;
      endcase
      if (clear) begin
         next_state = ENTRY;
      end
   end

   // A word is on offer exactly while the machine sits in HOLD.
   always_comb begin
      valid = (state == HOLD);
   end

   // Shift in digits only while collecting; a taken word stays visible until the next digit arrives.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         value     <= '0;
         digit_idx <= '0;
      end else if (clear) begin
         value     <= '0;
         digit_idx <= '0;
      end else if ((state == ENTRY) && press) begin
         value     <= {value[11:0], sw_nibble};
         digit_idx <= (digit_idx == LAST_IDX) ? 2'd0 : digit_idx + 2'd1;
      end
   end

   // The debounced level itself is only needed inside the debouncer.
   logic unused_level;
   assign unused_level = key_level;

endmodule
